vga_timing_gen: RTL and testbench

Video timing generator for the video controller, clocked by `pixel_clk` (32 MHz, 800x480 panel). It produces the HS/VS/BLANK signals for the display and a per-pixel request that drains the pixel FIFO. That FIFO is filled from SDRAM by the Wishbone stream side. It also tracks the pixel position, flags FIFO underflow, and starts and stops only on frame boundaries.

---
 rtl/vga_timing_gen.sv | 153 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Video timing generator: HS/VS/BLANK, pixel position and a FIFO read strobe
// for a raster panel; runs and stops only on frame boundaries.
module vga_timing_gen #(
  parameter  int HDISP  = 800,
  parameter  int HFP    = 40,
  parameter  int HPULSE = 48,
  parameter  int HBP    = 40,
  parameter  int VDISP  = 480,
  parameter  int VFP    = 13,
  parameter  int VPULSE = 3,
  parameter  int VBP    = 29,
  localparam int HTOTAL = HDISP + HFP + HPULSE + HBP,
  localparam int VTOTAL = VDISP + VFP + VPULSE + VBP,
  localparam int HW     = $clog2(HTOTAL),
  localparam int VW     = $clog2(VTOTAL)
) (
  input  logic          pixel_clk,
  input  logic          pixel_rst,
  input  logic          enable,
  input  logic          fifo_empty,
  output logic          pixel_req,
  output logic          frame_start,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_BLANK,
  output logic [HW-1:0] pixel_x,
  output logic [VW-1:0] pixel_y,
  output logic          underflow
);

  localparam logic [HW-1:0] H_ZERO     = {HW{1'b0}};
  localparam logic [VW-1:0] V_ZERO     = {VW{1'b0}};
  localparam logic [HW-1:0] H_LAST     = HW'(HTOTAL - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(VTOTAL - 1);
  localparam logic [HW-1:0] H_DISP     = HW'(HDISP);
  localparam logic [VW-1:0] V_DISP     = VW'(VDISP);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(HDISP + HFP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(HDISP + HFP + HPULSE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(VDISP + VFP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(VDISP + VFP + VPULSE);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state_r;
  logic [HW-1:0] hcnt_r;
  logic [VW-1:0] vcnt_r;
  logic          hs_r;
  logic          vs_r;
  logic          blank_r;
  logic [HW-1:0] px_r;
  logic [VW-1:0] py_r;
  logic          uf_r;

  logic          visible_s;
  logic          hsync_s;
  logic          vsync_s;
  logic          h_wrap_s;
  logic          v_wrap_s;

  // Decode of the counter registers for the current cycle
  always_comb begin
    visible_s = 1'b0;
    hsync_s   = 1'b0;
    vsync_s   = 1'b0;
    h_wrap_s  = 1'b0;
    v_wrap_s  = 1'b0;
    if (state_r == RUN) begin
      visible_s = (hcnt_r < H_DISP) && (vcnt_r < V_DISP);
      hsync_s   = (hcnt_r >= H_SYNC_BEG) && (hcnt_r < H_SYNC_END);
      vsync_s   = (vcnt_r >= V_SYNC_BEG) && (vcnt_r < V_SYNC_END);
      h_wrap_s  = (hcnt_r == H_LAST);
      v_wrap_s  = (vcnt_r == V_LAST);
    end else begin
      visible_s = 1'b0;
    end
  end

  assign pixel_req   = visible_s;
  assign frame_start = visible_s && (hcnt_r == H_ZERO) && (vcnt_r == V_ZERO);
  assign VGA_HS      = hs_r;
  assign VGA_VS      = vs_r;
  assign VGA_BLANK   = blank_r;
  assign pixel_x     = px_r;
  assign pixel_y     = py_r;
  assign underflow   = uf_r;

  // Run/idle FSM, raster counters and the one-cycle-delayed display outputs
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      state_r <= IDLE;
      hcnt_r  <= H_ZERO;
      vcnt_r  <= V_ZERO;
      hs_r    <= 1'b1;
      vs_r    <= 1'b1;
      blank_r <= 1'b0;
      px_r    <= H_ZERO;
      py_r    <= V_ZERO;
      uf_r    <= 1'b0;
    end else begin
      uf_r <= uf_r | (visible_s & fifo_empty);
      case (state_r)
        IDLE: begin
          hcnt_r  <= H_ZERO;
          vcnt_r  <= V_ZERO;
          hs_r    <= 1'b1;
          vs_r    <= 1'b1;
          blank_r <= 1'b0;
          px_r    <= H_ZERO;
          py_r    <= V_ZERO;
          if (enable) begin
            state_r <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          hs_r    <= ~hsync_s;
          vs_r    <= ~vsync_s;
          blank_r <= visible_s;
          px_r    <= hcnt_r;
          py_r    <= vcnt_r;
          if (h_wrap_s) begin
            hcnt_r <= H_ZERO;
            if (v_wrap_s) begin
              vcnt_r <= V_ZERO;
              // a stop request only takes effect once the whole frame is out
              if (!enable) begin
                state_r <= IDLE;
              end else begin
                state_r <= RUN;
              end
            end else begin
              vcnt_r <= vcnt_r + VW'(1);
            end
          end else begin
            hcnt_r <= hcnt_r + HW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          hcnt_r  <= H_ZERO;
          vcnt_r  <= V_ZERO;
          hs_r    <= 1'b1;
          vs_r    <= 1'b1;
          blank_r <= 1'b0;
          px_r    <= H_ZERO;
          py_r    <= V_ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboarded bench for vga_timing_gen on a reduced 30x20 raster: a frame-position
// model queues expected outputs per cycle, a monitor pops and compares them.
module tb_vga_timing_gen;
  localparam int HD = 16, HF = 4, HP = 6, HB = 4;
  localparam int VD = 10, VF = 2, VP = 3, VB = 5;
  localparam int HT = 30, VT = 20, FR = 600;
  localparam int XW = 5, YW = 5, EW = 16;
  localparam logic [EW-1:0] RST_V = 16'h3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, en = 1'b0, empty = 1'b0;
  logic pixel_req, frame_start, VGA_HS, VGA_VS, VGA_BLANK, underflow;
  logic [XW-1:0] pixel_x;
  logic [YW-1:0] pixel_y;
  logic [EW-1:0] act_v;

  vga_timing_gen #(.HDISP(HD), .HFP(HF), .HPULSE(HP), .HBP(HB),
                   .VDISP(VD), .VFP(VF), .VPULSE(VP), .VBP(VB)) dut (
    .pixel_clk(clk), .pixel_rst(rst), .enable(en), .fifo_empty(empty),
    .pixel_req(pixel_req), .frame_start(frame_start), .VGA_HS(VGA_HS),
    .VGA_VS(VGA_VS), .VGA_BLANK(VGA_BLANK), .pixel_x(pixel_x),
    .pixel_y(pixel_y), .underflow(underflow));

  assign act_v = {pixel_req, frame_start, VGA_HS, VGA_VS, VGA_BLANK, pixel_x, pixel_y, underflow};

  int total = 0, bad = 0;
  logic [EW-1:0] exp_q[$];

  // frame model: running flag plus linear position inside the frame
  bit m_run = 1'b0, m_hs = 1'b1, m_vs = 1'b1, m_blank = 1'b0, m_uf = 1'b0;
  int m_pos = 0, m_px = 0, m_py = 0;

  task automatic model_push();
    int h, v;
    bit req_pre, req, fs;
    h = m_pos % HT;
    v = m_pos / HT;
    req_pre = m_run && (h < HD) && (v < VD);
    if (rst) begin
      m_run = 1'b0; m_pos = 0; m_hs = 1'b1; m_vs = 1'b1;
      m_blank = 1'b0; m_px = 0; m_py = 0; m_uf = 1'b0;
    end else begin
      if (req_pre && empty) m_uf = 1'b1;
      if (m_run) begin
        m_hs = !((h >= HD + HF) && (h < HD + HF + HP));
        m_vs = !((v >= VD + VF) && (v < VD + VF + VP));
        m_blank = req_pre; m_px = h; m_py = v;
      end else begin
        m_hs = 1'b1; m_vs = 1'b1; m_blank = 1'b0; m_px = 0; m_py = 0;
      end
      if (!m_run) begin
        m_run = en; m_pos = 0;
      end else if (m_pos == FR - 1) begin
        m_pos = 0; m_run = en;
      end else begin
        m_pos++;
      end
    end
    h = m_pos % HT;
    v = m_pos / HT;
    req = m_run && (h < HD) && (v < VD);
    fs = req && (m_pos == 0);
    exp_q.push_back({req, fs, m_hs, m_vs, m_blank, XW'(m_px), YW'(m_py), m_uf});
  endtask

  task automatic step();
    @(negedge clk);
    model_push();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic run_to(input int pos, input string name);
    int n = 0;
    while (m_pos != pos && n < 2 * FR) begin
      step();
      n++;
    end
    if (m_pos != pos) begin
      total++;
      bad++;
      $display("FAIL %s timeout actual_pos=%0d expected_pos=%0d", name, m_pos, pos);
    end
  endtask

  // monitor: one queued expectation per clock edge
  always @(posedge clk) begin
    logic [EW-1:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (act_v !== e) begin
        bad++;
        if (bad <= 10) $display("FAIL scoreboard t=%0t actual=%h expected=%h", $time, act_v, e);
      end
    end
  end

  initial begin
    int fs_prev, fs_gap, req_line, hs_low, hs_first, vs_low, hs_fall, blank_rise, n;
    logic hs_d, blank_d;

    rst = 1'b1; en = 1'b0; empty = 1'b0;
    repeat (3) step();
    chk("reset_vector", act_v, RST_V);
    rst = 1'b0;
    step();
    chk("idle_no_req", pixel_req, 0);

    en = 1'b1;
    step();
    chk("req_latency", pixel_req, 1);
    chk("first_frame_start", frame_start, 1);
    chk("blank_not_yet", VGA_BLANK, 0);

    fs_prev = 0; fs_gap = -1; req_line = 0; hs_low = 0; hs_first = -1;
    vs_low = 0; hs_fall = 0; blank_rise = 0; hs_d = 1'b1; blank_d = VGA_BLANK;
    for (int i = 0; i < 2 * FR; i++) begin
      if (i > 0) step();
      if (i == 1) chk("blank_first", VGA_BLANK, 1);
      if (frame_start && i > 0) begin
        fs_gap = i - fs_prev;
        fs_prev = i;
      end
      if (i < HT && pixel_req) req_line++;
      if (i <= HT && !VGA_HS) begin
        hs_low++;
        if (hs_first < 0) hs_first = i;
      end
      if (i >= 1 && i <= FR) begin
        if (!VGA_VS) vs_low++;
        if (hs_d && !VGA_HS) hs_fall++;
        if (!blank_d && VGA_BLANK) blank_rise++;
      end
      if (i == 9 * HT + 16) begin
        chk("spot_15_9_x", pixel_x, 15);
        chk("spot_15_9_blank", VGA_BLANK, 1);
      end
      if (i == 9 * HT + 17) begin
        chk("spot_16_9_x", pixel_x, 16);
        chk("spot_16_9_blank", VGA_BLANK, 0);
      end
      hs_d = VGA_HS;
      blank_d = VGA_BLANK;
    end
    chk("frame_period", fs_gap, FR);
    chk("req_per_line", req_line, HD);
    chk("hs_low_width", hs_low, HP);
    chk("hs_low_start", hs_first, HD + HF + 1);
    chk("vs_low_cycles", vs_low, VP * HT);
    chk("hs_falls_per_frame", hs_fall, VT);
    chk("blank_rises_per_frame", blank_rise, VD);

    // single empty cycle in horizontal blanking must not flag underflow
    run_to(HD + 2, "wait_hblank");
    empty = 1'b1; step(); empty = 1'b0; step();
    chk("no_underflow_in_blank", underflow, 0);
    run_to(2 * HT + 3, "wait_visible");
    empty = 1'b1; step(); empty = 1'b0; step();
    chk("underflow_set", underflow, 1);
    repeat (FR) step();
    chk("underflow_sticky", underflow, 1);

    // stop request on line 5: frame runs out, then idle at reset values
    run_to(5 * HT, "wait_line5");
    en = 1'b0;
    n = 0;
    while (!(pixel_x == XW'(HT - 1) && pixel_y == YW'(VT - 1)) && n < FR + 10) begin
      step();
      n++;
    end
    chk("drop_runs_to_frame_end", n, FR - 5 * HT);
    step(); step();
    chk("idle_after_drop", act_v, RST_V | 16'h0001);
    n = 0;
    repeat (50) begin
      step();
      if (pixel_req) n++;
    end
    chk("idle_req_count", n, 0);

    // enable glitch mid-frame must not interrupt the raster
    en = 1'b1;
    step();
    chk("restart_frame_start", frame_start, 1);
    n = 0;
    do begin
      if (n == 7 * HT) en = 1'b0;
      if (n == 7 * HT + 3) en = 1'b1;
      step();
      n++;
    end while (!frame_start && n < 2 * FR);
    chk("glitch_frame_period", n, FR);

    // synchronous reset mid-frame, enable held high
    run_to(4 * HT + 8, "wait_rst_point");
    rst = 1'b1;
    step();
    chk("rst_vector", act_v, RST_V);
    rst = 1'b0;
    step();
    chk("fs_after_rst", frame_start, 1);
    chk("uf_after_rst", underflow, 0);
    repeat (5) step();

    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
